divider_seq_ctrl: RTL and testbench

//  Upstream sequencer for the iterative divider. Accepts a dividend/divisor request over a valid/ready handshake.

---
 rtl/divider_seq_ctrl_if.sv | 25 ++
 rtl/divider_seq_ctrl.sv | 101 ++++++++++
 tb/tb_divider_seq_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/divider_seq_ctrl_if.sv
// Request/response handshake bundle between a client and the divider sequencer.
interface divider_seq_ctrl_if #(
   parameter int C_NUM_BITS = 4
);
   logic                  REQ_VALID;
   logic                  REQ_READY;
   logic [C_NUM_BITS-1:0] DIVIDEND;
   logic [C_NUM_BITS-1:0] DIVISOR;
   logic                  RSP_VALID;
   logic                  RSP_READY;
   logic [C_NUM_BITS-1:0] RSP_QUO;
   logic                  RSP_DZ;

   // client side: issues requests, consumes responses
   modport master (
      output REQ_VALID, DIVIDEND, DIVISOR, RSP_READY,
      input  REQ_READY, RSP_VALID, RSP_QUO, RSP_DZ
   );

   // sequencer side
   modport slave (
      input  REQ_VALID, DIVIDEND, DIVISOR, RSP_READY,
      output REQ_READY, RSP_VALID, RSP_QUO, RSP_DZ
   );
endinterface

// File: rtl/divider_seq_ctrl.sv
// Sequencer for the iterative divider: accepts operands, clears and runs the
// divider for a fixed number of enabled edges, captures Q and returns it.
// Divide-by-zero is answered directly with an all-ones quotient.
module divider_seq_ctrl #(
   parameter int C_NUM_BITS   = 4,
   parameter int C_DIV_CYCLES = 10,
   parameter int C_CNT_BITS   = 8
) (
   input  logic                  CK,
   input  logic                  R,
   divider_seq_ctrl_if.slave     io,
   output logic                  BUSY,
   output logic [C_CNT_BITS-1:0] OP_CNT,
   output logic                  DIV_RN,
   output logic                  DIV_E,
   output logic [C_NUM_BITS-1:0] DIV_A,
   output logic [C_NUM_BITS-1:0] DIV_B,
   input  logic [C_NUM_BITS-1:0] DIV_Q
);

   localparam int CYC_BITS = $clog2(C_DIV_CYCLES + 1);
   localparam logic [CYC_BITS-1:0] CYC_LAST = CYC_BITS'(C_DIV_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t                state, state_nxt;
   logic [CYC_BITS-1:0]   cyc;
   logic [C_NUM_BITS-1:0] op_a, op_b;
   logic [C_NUM_BITS-1:0] rsp_quo;
   logic                  rsp_dz;
   logic [C_CNT_BITS-1:0] op_cnt;
   logic                  accept;
   logic                  divisor_zero;

   assign accept       = io.REQ_VALID && (state == S_IDLE);
   assign divisor_zero = (io.DIVISOR == '0);

   // State register
   always_ff @(posedge CK) begin
      if (R) state <= S_IDLE;
      else   state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (accept) state_nxt = divisor_zero ? S_DONE : S_CLEAR;
         S_CLEAR:   state_nxt = S_RUN;
         S_RUN:     if (cyc == CYC_LAST) state_nxt = S_CAPTURE;
         S_CAPTURE: state_nxt = S_DONE;
         S_DONE:    if (io.RSP_READY) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Operand latch, iteration counter, result capture and completion counter
   always_ff @(posedge CK) begin
      if (R) begin
         op_a    <= '0;
         op_b    <= '0;
         rsp_quo <= '0;
         rsp_dz  <= 1'b0;
         cyc     <= '0;
         op_cnt  <= '0;
      end else begin
         if (accept) begin
            op_a    <= io.DIVIDEND;
            op_b    <= io.DIVISOR;
            rsp_dz  <= divisor_zero;
            rsp_quo <= divisor_zero ? '1 : '0;
         end
         if (state == S_CLEAR)      cyc <= '0;
         else if (state == S_RUN)   cyc <= cyc + 1'b1;
         if (state == S_CAPTURE)    rsp_quo <= DIV_Q;
         if ((state == S_DONE) && io.RSP_READY && (op_cnt != '1))
            op_cnt <= op_cnt + 1'b1;
      end
   end

   // Outputs decode purely from registered state and datapath registers
   always_comb begin
      io.REQ_READY = (state == S_IDLE);
      io.RSP_VALID = (state == S_DONE);
      io.RSP_QUO   = rsp_quo;
      io.RSP_DZ    = rsp_dz;
      BUSY         = (state != S_IDLE);
      OP_CNT       = op_cnt;
      DIV_RN       = (state == S_RUN) || (state == S_CAPTURE);
      DIV_E        = (state == S_RUN);
      DIV_A        = op_a;
      DIV_B        = op_b;
   end

endmodule

// File: tb/tb_divider_seq_ctrl.sv
// Self-checking bench for divider_seq_ctrl with a behavioural divider that
// only presents the true quotient after enough enabled edges.
module tb_divider_seq_ctrl;

   localparam int NB  = 4;
   localparam int DC  = 10;
   localparam int CB  = 8;

   typedef struct {
      logic [NB-1:0] quo;
      logic          dz;
   } exp_t;

   logic          CK = 1'b0;
   logic          R  = 1'b1;
   logic          BUSY;
   logic [CB-1:0] OP_CNT;
   logic          DIV_RN, DIV_E;
   logic [NB-1:0] DIV_A, DIV_B, DIV_Q;

   int unsigned   total = 0;
   int unsigned   bad   = 0;
   int unsigned   exp_cnt = 0;
   exp_t          sb[$];

   divider_seq_ctrl_if #(.C_NUM_BITS(NB)) io ();

   divider_seq_ctrl #(
      .C_NUM_BITS(NB),
      .C_DIV_CYCLES(DC),
      .C_CNT_BITS(CB)
   ) dut (
      .CK(CK),
      .R(R),
      .io(io),
      .BUSY(BUSY),
      .OP_CNT(OP_CNT),
      .DIV_RN(DIV_RN),
      .DIV_E(DIV_E),
      .DIV_A(DIV_A),
      .DIV_B(DIV_B),
      .DIV_Q(DIV_Q)
   );

   always #5 CK = ~CK;

   // Divider model: cleared while RN is low, counts enabled edges; Q is wrong
   // until DC enabled edges have been seen.
   int unsigned mcnt = 0;
   always @(posedge CK) begin
      if (!DIV_RN)    mcnt <= 0;
      else if (DIV_E) mcnt <= mcnt + 1;
   end

   always_comb begin
      logic [NB-1:0] fq;
      fq = '0;
      if (DIV_B != '0) fq = DIV_A / DIV_B;
      DIV_Q = (mcnt >= DC) ? fq : ~fq;
   end

   task automatic run_op(input logic [NB-1:0] a, input logic [NB-1:0] b,
                         input bit hold_valid, input int stall);
      exp_t e, got;
      int   lat;
      int   exp_lat;
      bit   ready_err, ab_err, saw_e, hold_err;
      logic [NB-1:0] q0;
      logic [CB-1:0] c0;
      ready_err = 0; ab_err = 0; saw_e = 0; hold_err = 0;
      exp_lat = (b == '0) ? 1 : DC + 3;
      io.RSP_READY = (stall == 0);
      io.REQ_VALID = 1'b1;
      io.DIVIDEND  = a;
      io.DIVISOR   = b;
      e.quo = (b == '0) ? '1 : a / b;
      e.dz  = (b == '0);
      sb.push_back(e);
      total++;
      if (io.REQ_READY !== 1'b1) begin
         bad++;
         $display("FAIL req_ready_idle: got %b want 1", io.REQ_READY);
      end
      @(posedge CK);
      lat = 1;
      @(negedge CK);
      if (hold_valid) begin
         io.DIVIDEND = ~a;
         io.DIVISOR  = b ^ 4'h5;
      end else begin
         io.REQ_VALID = 1'b0;
      end
      while (!io.RSP_VALID && lat < 100) begin
         if (io.REQ_READY !== 1'b0 || BUSY !== 1'b1) ready_err = 1;
         if (DIV_E) saw_e = 1;
         if (DIV_A !== a || DIV_B !== b) ab_err = 1;
         @(posedge CK);
         lat++;
         @(negedge CK);
      end
      io.REQ_VALID = 1'b0;
      total++;
      if (lat !== exp_lat) begin
         bad++;
         $display("FAIL latency %0d/%0d: got %0d want %0d", a, b, lat, exp_lat);
      end
      total++;
      if (ready_err) begin
         bad++;
         $display("FAIL ready_low_busy %0d/%0d: got ready/busy wrong want 0/1", a, b);
      end
      total++;
      if (saw_e !== (b != '0)) begin
         bad++;
         $display("FAIL div_e_seen %0d/%0d: got %b want %b", a, b, saw_e, (b != '0));
      end
      total++;
      if (ab_err || DIV_A !== a || DIV_B !== b) begin
         bad++;
         $display("FAIL div_ab_stable: got %0d/%0d want %0d/%0d", DIV_A, DIV_B, a, b);
      end
      got.quo = io.RSP_QUO;
      got.dz  = io.RSP_DZ;
      if (sb.size() == 0) begin
         total++; bad++;
         $display("FAIL scoreboard_empty: got response want none");
      end else begin
         e = sb.pop_front();
         total++;
         if (got.quo !== e.quo || got.dz !== e.dz) begin
            bad++;
            $display("FAIL rsp %0d/%0d: got quo=%h dz=%b want quo=%h dz=%b",
                     a, b, got.quo, got.dz, e.quo, e.dz);
         end
      end
      q0 = io.RSP_QUO;
      c0 = OP_CNT;
      for (int i = 0; i < stall; i++) begin
         @(posedge CK);
         @(negedge CK);
         if (io.RSP_VALID !== 1'b1 || io.RSP_QUO !== q0 || OP_CNT !== c0)
            hold_err = 1;
      end
      if (stall > 0) begin
         total++;
         if (hold_err) begin
            bad++;
            $display("FAIL rsp_hold: got valid=%b quo=%h cnt=%0d want 1 %h %0d",
                     io.RSP_VALID, io.RSP_QUO, OP_CNT, q0, c0);
         end
      end
      io.RSP_READY = 1'b1;
      @(posedge CK);
      @(negedge CK);
      io.RSP_READY = 1'b0;
      if (exp_cnt < (1 << CB) - 1) exp_cnt++;
      total++;
      if (io.RSP_VALID !== 1'b0 || io.REQ_READY !== 1'b1 || OP_CNT !== CB'(exp_cnt)) begin
         bad++;
         $display("FAIL after_handshake: got valid=%b ready=%b cnt=%0d want 0 1 %0d",
                  io.RSP_VALID, io.REQ_READY, OP_CNT, exp_cnt);
      end
   endtask

   task automatic test_reset();
      R = 1'b1;
      io.REQ_VALID = 1'b1;
      io.DIVIDEND  = 4'd7;
      io.DIVISOR   = 4'd0;
      io.RSP_READY = 1'b0;
      repeat (3) @(posedge CK);
      @(negedge CK);
      total++;
      if (io.REQ_READY !== 1'b1 || io.RSP_VALID !== 1'b0 || io.RSP_QUO !== '0 ||
          io.RSP_DZ !== 1'b0 || BUSY !== 1'b0 || OP_CNT !== '0 || DIV_RN !== 1'b0 ||
          DIV_E !== 1'b0 || DIV_A !== '0 || DIV_B !== '0) begin
         bad++;
         $display("FAIL reset_state: got rdy=%b vld=%b quo=%h dz=%b busy=%b cnt=%0d rn=%b e=%b a=%h b=%h want 1 0 0 0 0 0 0 0 0 0",
                  io.REQ_READY, io.RSP_VALID, io.RSP_QUO, io.RSP_DZ, BUSY, OP_CNT,
                  DIV_RN, DIV_E, DIV_A, DIV_B);
      end
      io.REQ_VALID = 1'b0;
      R = 1'b0;
      @(posedge CK);
      @(negedge CK);
      total++;
      if (BUSY !== 1'b0) begin
         bad++;
         $display("FAIL idle_after_release: got busy=%b want 0", BUSY);
      end
      exp_cnt = 0;
   endtask

   task automatic test_basic();
      run_op(4'd7, 4'd2, 1'b0, 0);
   endtask

   task automatic test_back_to_back();
      run_op(4'd15, 4'd1, 1'b1, 0);
      run_op(4'd9, 4'd3, 1'b1, 0);
      run_op(4'd14, 4'd5, 1'b0, 0);
   endtask

   task automatic test_div_zero();
      run_op(4'd5, 4'd0, 1'b0, 0);
   endtask

   task automatic test_backpressure();
      run_op(4'd13, 4'd4, 1'b0, 5);
      run_op(4'd3, 4'd0, 1'b0, 5);
   endtask

   task automatic test_reset_mid();
      bit saw_rsp;
      saw_rsp = 0;
      io.RSP_READY = 1'b1;
      io.REQ_VALID = 1'b1;
      io.DIVIDEND  = 4'd7;
      io.DIVISOR   = 4'd2;
      @(posedge CK);           // accept -> CLEAR
      @(negedge CK);
      io.REQ_VALID = 1'b0;
      repeat (4) @(posedge CK); // into 4th RUN cycle
      @(negedge CK);
      total++;
      if (DIV_E !== 1'b1 || DIV_RN !== 1'b1) begin
         bad++;
         $display("FAIL run_before_reset: got e=%b rn=%b want 1 1", DIV_E, DIV_RN);
      end
      R = 1'b1;
      @(posedge CK);
      @(negedge CK);
      R = 1'b0;
      exp_cnt = 0;
      total++;
      if (BUSY !== 1'b0 || DIV_RN !== 1'b0 || DIV_E !== 1'b0 || io.RSP_VALID !== 1'b0 ||
          io.REQ_READY !== 1'b1 || OP_CNT !== '0) begin
         bad++;
         $display("FAIL reset_mid: got busy=%b rn=%b e=%b vld=%b rdy=%b cnt=%0d want 0 0 0 0 1 0",
                  BUSY, DIV_RN, DIV_E, io.RSP_VALID, io.REQ_READY, OP_CNT);
      end
      repeat (20) begin
         @(posedge CK);
         @(negedge CK);
         if (io.RSP_VALID || BUSY) saw_rsp = 1;
      end
      io.RSP_READY = 1'b0;
      total++;
      if (saw_rsp) begin
         bad++;
         $display("FAIL reset_discard: got response/busy want none");
      end
   endtask

   task automatic test_saturation();
      for (int unsigned i = 0; i < 256; i++)
         run_op(4'(i), (i % 17 == 3) ? 4'd3 : 4'd0, 1'b0, 0);
      total++;
      if (OP_CNT !== 8'hFF) begin
         bad++;
         $display("FAIL op_cnt_sat: got %h want ff", OP_CNT);
      end
   endtask

   initial begin
      io.REQ_VALID = 1'b0;
      io.DIVIDEND  = '0;
      io.DIVISOR   = '0;
      io.RSP_READY = 1'b0;
      @(negedge CK);
      test_reset();
      test_basic();
      test_back_to_back();
      test_div_zero();
      test_backpressure();
      test_reset_mid();
      test_saturation();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_leftover: got %0d want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
